// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the countdown display
package traffic_pkg;
  typedef enum logic [1:0] {IDLE, CONV_A, CONV_B} conv_state_t;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int CLAMP_MAX = 99;
  localparam logic [1:0] DIG_A_TENS = 2'd0;
  localparam logic [1:0] DIG_A_UNITS = 2'd1;
  localparam logic [1:0] DIG_B_TENS = 2'd2;
  localparam logic [1:0] DIG_B_UNITS = 2'd3;
  // Values above 99 cannot be shown in two digits, so saturate them
  function automatic logic [6:0] clamp99(input logic [6:0] v);
    return (v > 7'(CLAMP_MAX)) ? 7'(CLAMP_MAX) : v;
  endfunction
  // One double-dabble step on {tens, units, binary}: add 3 to nibbles >= 5, then shift left
  function automatic logic [14:0] dd_step(input logic [14:0] s);
    logic [14:0] a;
    a = s;
    a[14:11] = (a[14:11] >= 4'd5) ? a[14:11] + 4'd3 : a[14:11];
    a[10:7] = (a[10:7] >= 4'd5) ? a[10:7] + 4'd3 : a[10:7];
    return {a[13:0], 1'b0};
  endfunction
endpackage

// File: rtl/traffic_countdown_display_seg7_encode.sv
// seg7_encode: BCD digit to active-low gfedcba segment pattern
module seg7_encode
  import traffic_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);
  // Non-decimal codes blank the digit rather than show garbage
  always_comb begin
    case (bcd)
      4'd0: seg_n = SEG_0;
      4'd1: seg_n = SEG_1;
      4'd2: seg_n = SEG_2;
      4'd3: seg_n = SEG_3;
      4'd4: seg_n = SEG_4;
      4'd5: seg_n = SEG_5;
      4'd6: seg_n = SEG_6;
      4'd7: seg_n = SEG_7;
      4'd8: seg_n = SEG_8;
      4'd9: seg_n = SEG_9;
      default: seg_n = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/traffic_countdown_display.sv
// traffic_countdown_display: two countdowns -> BCD -> 4-digit muxed 7-seg; LEADING_ZERO_BLANK_EN blanks zero tens digits
module traffic_countdown_display
  import traffic_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic [CNT_W-1:0] cnt_b,
  output logic             busy,
  output logic             done,
  output logic [6:0]       seg_n,
  output logic [3:0]       dig_n
);
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  conv_state_t state;
  logic [2:0] bit_cnt;
  logic [14:0] shifter;
  logic [14:0] stepped;
  logic [6:0] cap_b;
  logic [7:0] tmp_a;
  logic [15:0] disp;
  logic pending;
  logic [SW-1:0] scan_cnt;
  logic [1:0] scan_idx;
  logic tick;
  logic [3:0] cur;
  logic [6:0] enc;
  logic blank;
  assign stepped = dd_step(shifter);
  assign tick = scan_cnt == SW'(SCAN_DIV - 1);
  assign cur = (scan_idx == DIG_A_TENS) ? disp[15:12] :
               (scan_idx == DIG_A_UNITS) ? disp[11:8] :
               (scan_idx == DIG_B_TENS) ? disp[7:4] : disp[3:0];
`ifdef LEADING_ZERO_BLANK_EN
  assign blank = !scan_idx[0] && cur == 4'd0;
`else
  assign blank = 1'b0;
`endif
  seg7_encode u_enc (.bcd(cur), .seg_n(enc));
  // Shared converter: A then B, display digits swap in together at the end of B
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bit_cnt <= 3'd0;
      shifter <= 15'd0;
      cap_b <= 7'd0;
      tmp_a <= 8'd0;
      disp <= 16'd0;
      pending <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (load || pending) begin
          shifter <= {8'd0, clamp99(cnt_a)};
          cap_b <= clamp99(cnt_b);
          pending <= 1'b0;
          busy <= 1'b1;
          bit_cnt <= 3'd0;
          state <= CONV_A;
        end
      end else begin
        if (load) pending <= 1'b1;
        bit_cnt <= bit_cnt + 3'd1;
        shifter <= stepped;
        if (bit_cnt == 3'd6) begin
          bit_cnt <= 3'd0;
          if (state == CONV_A) begin
            tmp_a <= stepped[14:7];
            shifter <= {8'd0, cap_b};
            state <= CONV_B;
          end else begin
            disp <= {tmp_a, stepped[14:7]};
            busy <= 1'b0;
            done <= 1'b1;
            state <= IDLE;
          end
        end
      end
    end
  end
  // Free-running refresh divider steps the digit slot on each terminal count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= 2'd0;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
      scan_idx <= tick ? scan_idx + 2'd1 : scan_idx;
    end
  end
  // Pin drivers registered every cycle from the current slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_n <= SEG_BLANK;
      dig_n <= 4'hF;
    end else begin
      seg_n <= blank ? SEG_BLANK : enc;
      dig_n <= ~(4'b0001 << scan_idx);
    end
  end
endmodule

// File: tb/tb_traffic_countdown_display.sv
// tb_traffic_countdown_display: directed and random checks against a decimal-digit reference model
module tb_traffic_countdown_display;
  localparam int SD = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic [6:0] cnt_a = 7'd0;
  logic [6:0] cnt_b = 7'd0;
  logic busy, done;
  logic [6:0] seg_n;
  logic [3:0] dig_n;
  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  traffic_countdown_display #(.SCAN_DIV(SD), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .load(load), .cnt_a(cnt_a), .cnt_b(cnt_b),
    .busy(busy), .done(done), .seg_n(seg_n), .dig_n(dig_n)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) n_done++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int slot, input int a, input int b);
    int ca, cb, d;
    ca = (a > 99) ? 99 : a;
    cb = (b > 99) ? 99 : b;
    d = (slot == 0) ? ca / 10 : (slot == 1) ? ca % 10 : (slot == 2) ? cb / 10 : cb % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot % 2 == 0 && d == 0) return 7'h7F;
`endif
    return seg_tab[d];
  endfunction

  task automatic window(input int a, input int b, input int n);
    int slot;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      slot = 0;
      for (int i = 0; i < 4; i++) if (!dig_n[i]) slot = i;
      chk("dig_onehot", 16'($countones(~dig_n)), 16'd1);
      chk($sformatf("seg_slot%0d", slot), 16'(seg_n), 16'(exp_seg(slot, a, b)));
    end
  endtask

  task automatic wait_done(output int bc, output bit ok);
    bc = 0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (done) ok = 1'b1;
      else begin
        if (busy) bc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic convert_check(input int a, input int b);
    int bc;
    bit ok;
    @(negedge clk);
    load = 1'b1;
    cnt_a = 7'(a);
    cnt_b = 7'(b);
    @(negedge clk);
    load = 1'b0;
    wait_done(bc, ok);
    chk("done_seen", 16'(ok), 16'd1);
    chk("busy_cycles", 16'(bc), 16'd14);
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", 16'(done), 16'd0);
    window(a, b, 4 * SD);
  endtask

  initial begin
    int bc, d0;
    bit ok;
    logic [3:0] e;
    #12;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_seg", 16'(seg_n), 16'h7F);
    chk("rst_dig", 16'(dig_n), 16'hF);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = ~(4'b0001 << (((k - 1) / SD) % 4));
      chk("scan_dig", 16'(dig_n), 16'(e));
    end
    convert_check(55, 65);
    convert_check(120, 100);
    convert_check(5, 0);
    convert_check(0, 99);
    repeat (6) convert_check(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
    d0 = n_done;
    @(negedge clk);
    load = 1'b1;
    cnt_a = 7'd40;
    cnt_b = 7'd30;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    load = 1'b1;
    cnt_a = 7'd77;
    cnt_b = 7'd77;
    @(negedge clk);
    @(negedge clk);
    load = 1'b0;
    cnt_a = 7'd15;
    cnt_b = 7'd5;
    wait_done(bc, ok);
    chk("pend_first_done", 16'(ok), 16'd1);
    chk("pend_restart_busy", 16'(busy), 16'd0);
    window(40, 30, 15);
    chk("pend_second_done", 16'(done), 16'd1);
    window(15, 5, 4 * SD + 1);
    chk("pend_done_count", 16'(n_done - d0), 16'd2);
    chk("pend_idle", 16'(busy), 16'd0);
    @(negedge clk);
    load = 1'b1;
    cnt_a = 7'd88;
    cnt_b = 7'd88;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    d0 = n_done;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_done", 16'(done), 16'd0);
    chk("midrst_seg", 16'(seg_n), 16'h7F);
    chk("midrst_dig", 16'(dig_n), 16'hF);
    @(negedge clk);
    chk("midrst_seg_hold", 16'(seg_n), 16'h7F);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", 16'(n_done - d0), 16'd0);
    chk("midrst_idle", 16'(busy), 16'd0);
    window(0, 0, 4 * SD + 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
